// File: rtl/axi4_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter: shares one slave port between m0 and m1,
// keeps a single burst outstanding and routes R beats to the burst owner.
module axi4_rd_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clock,
    input  logic        rst_n,

    input  logic        m0_arvalid,
    output logic        m0_arready,
    input  logic [31:0] m0_araddr,
    input  logic [3:0]  m0_arid,
    input  logic [7:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    input  logic [1:0]  m0_arburst,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    output logic [63:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic [3:0]  m0_rid,
    output logic        m0_rlast,

    input  logic        m1_arvalid,
    output logic        m1_arready,
    input  logic [31:0] m1_araddr,
    input  logic [3:0]  m1_arid,
    input  logic [7:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    input  logic [1:0]  m1_arburst,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [63:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic [3:0]  m1_rid,
    output logic        m1_rlast,

    output logic        io_slave_arvalid,
    input  logic        io_slave_arready,
    output logic [31:0] io_slave_araddr,
    output logic [3:0]  io_slave_arid,
    output logic [7:0]  io_slave_arlen,
    output logic [2:0]  io_slave_arsize,
    output logic [1:0]  io_slave_arburst,
    input  logic        io_slave_rvalid,
    output logic        io_slave_rready,
    input  logic [63:0] io_slave_rdata,
    input  logic [1:0]  io_slave_rresp,
    input  logic        io_slave_rlast,
    input  logic [3:0]  io_slave_rid,

    output logic [1:0]  grant,
    output logic        proto_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state;
    logic        owner;       // 0 = m0, 1 = m1
    logic        last_owner;
    logic [7:0]  len_q;
    logic [8:0]  beat_cnt;

    logic        winner;
    logic        sel_arvalid;
    logic        sel_rready;
    logic        in_addr;
    logic        in_data;
    logic        ar_hs;
    logic        r_hs;
    logic        cnt_done;
    logic        burst_end;
    logic        fwd_last;

    // Ties go to m0 under fixed priority, otherwise to whoever did not own the last burst.
    always_comb begin
        winner = 1'b0;
        if (m0_arvalid && m1_arvalid)
            winner = FIXED_PRIO ? 1'b0 : ~last_owner;
        else
            winner = ~m0_arvalid;
    end

    assign in_addr     = (state == ADDR);
    assign in_data     = (state == DATA);
    assign sel_arvalid = owner ? m1_arvalid : m0_arvalid;
    assign sel_rready  = owner ? m1_rready  : m0_rready;

    assign io_slave_arvalid = in_addr && sel_arvalid;
    assign io_slave_araddr  = owner ? m1_araddr  : m0_araddr;
    assign io_slave_arid    = owner ? m1_arid    : m0_arid;
    assign io_slave_arlen   = owner ? m1_arlen   : m0_arlen;
    assign io_slave_arsize  = owner ? m1_arsize  : m0_arsize;
    assign io_slave_arburst = owner ? m1_arburst : m0_arburst;
    assign io_slave_rready  = in_data && sel_rready;

    assign m0_arready = in_addr && !owner && io_slave_arready;
    assign m1_arready = in_addr &&  owner && io_slave_arready;

    assign ar_hs     = io_slave_arvalid && io_slave_arready;
    assign r_hs      = io_slave_rvalid && io_slave_rready;
    assign cnt_done  = (beat_cnt == {1'b0, len_q});
    assign burst_end = r_hs && (io_slave_rlast || cnt_done);
    // The counted final beat is always flagged last, even if the slave forgot rlast.
    assign fwd_last  = io_slave_rlast || cnt_done;

    assign m0_rvalid = in_data && !owner && io_slave_rvalid;
    assign m1_rvalid = in_data &&  owner && io_slave_rvalid;
    assign m0_rdata  = io_slave_rdata;
    assign m1_rdata  = io_slave_rdata;
    assign m0_rresp  = io_slave_rresp;
    assign m1_rresp  = io_slave_rresp;
    assign m0_rid    = io_slave_rid;
    assign m1_rid    = io_slave_rid;
    assign m0_rlast  = m0_rvalid && fwd_last;
    assign m1_rlast  = m1_rvalid && fwd_last;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            len_q      <= 8'd0;
            beat_cnt   <= 9'd0;
            grant      <= 2'b00;
            proto_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_arvalid || m1_arvalid) begin
                        owner <= winner;
                        grant <= winner ? 2'b10 : 2'b01;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        len_q    <= io_slave_arlen;
                        beat_cnt <= 9'd0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs)
                        beat_cnt <= beat_cnt + 9'd1;
                    if (burst_end) begin
                        last_owner <= owner;
                        grant      <= 2'b00;
                        state      <= IDLE;
                        if (io_slave_rlast != cnt_done)
                            proto_err <= 1'b1;
                    end
                end
                default: begin
                    grant <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed scoreboard bench for axi4_rd_arbiter: a round-robin instance with a
// burst-capable slave stub, plus a fixed-priority instance with an always-ready slave.
`timescale 1ns/1ps
module tb_axi4_rd_arbiter;

    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          m;
        logic [63:0] data;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    beat_t      sb[$];
    logic [1:0] rr_grants[$];
    logic [1:0] fp_grants[$];
    logic [1:0] prev_grant;
    logic [1:0] fp_prev_grant;

    // Round-robin DUT signals
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [31:0] m0_araddr;
    logic [3:0]  m0_arid, m0_rid;
    logic [7:0]  m0_arlen;
    logic [2:0]  m0_arsize;
    logic [1:0]  m0_arburst, m0_rresp;
    logic [63:0] m0_rdata;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [31:0] m1_araddr;
    logic [3:0]  m1_arid, m1_rid;
    logic [7:0]  m1_arlen;
    logic [2:0]  m1_arsize;
    logic [1:0]  m1_arburst, m1_rresp;
    logic [63:0] m1_rdata;
    logic        io_slave_arvalid, io_slave_arready, io_slave_rvalid, io_slave_rready;
    logic        io_slave_rlast;
    logic [31:0] io_slave_araddr;
    logic [3:0]  io_slave_arid, io_slave_rid;
    logic [7:0]  io_slave_arlen;
    logic [2:0]  io_slave_arsize;
    logic [1:0]  io_slave_arburst, io_slave_rresp;
    logic [63:0] io_slave_rdata;
    logic [1:0]  grant;
    logic        proto_err;

    // Fixed-priority DUT signals
    logic        fp_m0_arvalid, fp_m1_arvalid;
    logic        fp_m0_arready, fp_m1_arready, fp_m0_rvalid, fp_m1_rvalid;
    logic        fp_m0_rlast, fp_m1_rlast;
    logic [63:0] fp_m0_rdata, fp_m1_rdata;
    logic [1:0]  fp_m0_rresp, fp_m1_rresp;
    logic [3:0]  fp_m0_rid, fp_m1_rid;
    logic        fp_io_slave_arvalid, fp_io_slave_rready;
    logic [31:0] fp_io_slave_araddr;
    logic [3:0]  fp_io_slave_arid;
    logic [7:0]  fp_io_slave_arlen;
    logic [2:0]  fp_io_slave_arsize;
    logic [1:0]  fp_io_slave_arburst;
    logic [1:0]  fp_grant;
    logic        fp_proto_err;

    // Slave stub: 0 = rlast on final beat, 1 = rlast tied high, 2 = rlast never
    logic [1:0]  rlast_mode;
    logic        s_busy;
    logic [7:0]  s_len, s_beat;
    logic [31:0] s_addr;
    logic [3:0]  s_id;

    function automatic logic [63:0] sdata(input logic [31:0] addr, input int beat);
        return {32'h0, (addr ^ 32'h3000_0413) + beat};
    endfunction

    assign io_slave_arready = !s_busy;
    assign io_slave_rvalid  = s_busy;
    assign io_slave_rdata   = sdata(s_addr, int'(s_beat));
    assign io_slave_rresp   = 2'b00;
    assign io_slave_rid     = s_id;
    assign io_slave_rlast   = (rlast_mode == 2'd1) ? 1'b1 :
                              (rlast_mode == 2'd2) ? 1'b0 : (s_beat == s_len);

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s_busy <= 1'b0;
            s_len  <= 8'd0;
            s_beat <= 8'd0;
            s_addr <= 32'h0;
            s_id   <= 4'h0;
        end else if (!s_busy) begin
            if (io_slave_arvalid) begin
                s_busy <= 1'b1;
                s_len  <= io_slave_arlen;
                s_beat <= 8'd0;
                s_addr <= io_slave_araddr;
                s_id   <= io_slave_arid;
            end
        end else if (io_slave_rready) begin
            s_beat <= s_beat + 8'd1;
            if (s_beat == s_len)
                s_busy <= 1'b0;
        end
    end

    axi4_rd_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .clock(clock), .rst_n(rst_n),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rid(m0_rid), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rid(m1_rid), .m1_rlast(m1_rlast),
        .io_slave_arvalid(io_slave_arvalid), .io_slave_arready(io_slave_arready),
        .io_slave_araddr(io_slave_araddr), .io_slave_arid(io_slave_arid),
        .io_slave_arlen(io_slave_arlen), .io_slave_arsize(io_slave_arsize),
        .io_slave_arburst(io_slave_arburst), .io_slave_rvalid(io_slave_rvalid),
        .io_slave_rready(io_slave_rready), .io_slave_rdata(io_slave_rdata),
        .io_slave_rresp(io_slave_rresp), .io_slave_rlast(io_slave_rlast),
        .io_slave_rid(io_slave_rid), .grant(grant), .proto_err(proto_err)
    );

    axi4_rd_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clock(clock), .rst_n(rst_n),
        .m0_arvalid(fp_m0_arvalid), .m0_arready(fp_m0_arready), .m0_araddr(32'h1000_0000),
        .m0_arid(4'h0), .m0_arlen(8'd0), .m0_arsize(3'd3), .m0_arburst(2'b01),
        .m0_rvalid(fp_m0_rvalid), .m0_rready(1'b1), .m0_rdata(fp_m0_rdata),
        .m0_rresp(fp_m0_rresp), .m0_rid(fp_m0_rid), .m0_rlast(fp_m0_rlast),
        .m1_arvalid(fp_m1_arvalid), .m1_arready(fp_m1_arready), .m1_araddr(32'h2000_0000),
        .m1_arid(4'h1), .m1_arlen(8'd0), .m1_arsize(3'd3), .m1_arburst(2'b01),
        .m1_rvalid(fp_m1_rvalid), .m1_rready(1'b1), .m1_rdata(fp_m1_rdata),
        .m1_rresp(fp_m1_rresp), .m1_rid(fp_m1_rid), .m1_rlast(fp_m1_rlast),
        .io_slave_arvalid(fp_io_slave_arvalid), .io_slave_arready(1'b1),
        .io_slave_araddr(fp_io_slave_araddr), .io_slave_arid(fp_io_slave_arid),
        .io_slave_arlen(fp_io_slave_arlen), .io_slave_arsize(fp_io_slave_arsize),
        .io_slave_arburst(fp_io_slave_arburst), .io_slave_rvalid(1'b1),
        .io_slave_rready(fp_io_slave_rready), .io_slave_rdata(64'h0),
        .io_slave_rresp(2'b00), .io_slave_rlast(1'b1),
        .io_slave_rid(4'h0), .grant(fp_grant), .proto_err(fp_proto_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input int m, input logic [63:0] d, input logic l, input logic [3:0] id);
        beat_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL beat_unexpected: observed beat from m%0d data=%0h expected=none", m, d);
            return;
        end
        e = sb.pop_front();
        chk("beat_owner", 64'(m), 64'(e.m));
        chk("beat_data", d, e.data);
        chk("beat_last", 64'(l), 64'(e.last));
        chk("beat_id", 64'(id), 64'(e.id));
    endtask

    always @(negedge clock) begin
        prev_grant    <= grant;
        fp_prev_grant <= fp_grant;
        if (rst_n) begin
            if (m0_rvalid && m0_rready) check_beat(0, m0_rdata, m0_rlast, m0_rid);
            if (m1_rvalid && m1_rready) check_beat(1, m1_rdata, m1_rlast, m1_rid);
            if (grant != 2'b00 && prev_grant == 2'b00) rr_grants.push_back(grant);
            if (fp_grant != 2'b00 && fp_prev_grant == 2'b00) fp_grants.push_back(fp_grant);
            if (grant == 2'b00 && io_slave_rvalid)
                chk("idle_r_blocked", {61'h0, m0_rvalid, m1_rvalid, io_slave_rready}, 64'h0);
            if (fp_grant == 2'b00)
                chk("fp_idle_r_blocked", {61'h0, fp_m0_rvalid, fp_m1_rvalid, fp_io_slave_rready}, 64'h0);
        end
    end

    task automatic push_beats(input int m, input logic [31:0] a, input logic [3:0] id, input int n);
        for (int b = 0; b < n; b++)
            sb.push_back('{m, sdata(a, b), (b == n - 1), id});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_grant"}, 64'(grant), 64'h0);
        chk({tag, "_outs"}, {56'h0, proto_err, io_slave_arvalid, io_slave_rready,
                             m0_arready, m1_arready, m0_rvalid, m1_rvalid, 1'b0}, 64'h0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clock); #1;
        rst_n = 1'b0;
        #1 check_reset(tag);
        repeat (2) @(posedge clock);
        @(negedge clock) rst_n = 1'b1;
    endtask

    task automatic issue(input string tag, input int m, input logic [31:0] a,
                         input logic [7:0] len, input logic [3:0] id);
        bit done = 1'b0;
        if (m == 0) begin
            m0_arvalid = 1'b1; m0_araddr = a; m0_arlen = len; m0_arid = id;
        end else begin
            m1_arvalid = 1'b1; m1_araddr = a; m1_arlen = len; m1_arid = id;
        end
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clock);
            if (m == 0) done = m0_arvalid && m0_arready;
            else        done = m1_arvalid && m1_arready;
        end
        @(posedge clock); #1;
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        chk({tag, "_ar_hs"}, 64'(done), 64'h1);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clock); #1;
            if (sb.size() == 0) break;
        end
        chk({tag, "_drained"}, 64'(sb.size()), 64'h0);
        chk({tag, "_idle_grant"}, 64'(grant), 64'h0);
    endtask

    initial begin
        int hs, n_m0, n_m1;
        bit got_m1;
        rst_n = 1'b0;
        m0_arvalid = 0; m0_araddr = 0; m0_arid = 0; m0_arlen = 0; m0_arsize = 3'd3; m0_arburst = 2'b01;
        m1_arvalid = 0; m1_araddr = 0; m1_arid = 0; m1_arlen = 0; m1_arsize = 3'd3; m1_arburst = 2'b01;
        m0_rready = 1'b1; m1_rready = 1'b1;
        fp_m0_arvalid = 1'b0; fp_m1_arvalid = 1'b0;
        rlast_mode = 2'd0;
        repeat (3) @(posedge clock);
        #1 check_reset("reset");
        @(negedge clock) rst_n = 1'b1;

        // Single-beat m0 read, cycle by cycle
        @(posedge clock); #1;
        m0_arvalid = 1'b1; m0_araddr = 32'h3000_0000; m0_arlen = 8'd0; m0_arid = 4'h1;
        push_beats(0, 32'h3000_0000, 4'h1, 1);
        #1 chk("t1_no_comb_arvalid", 64'(io_slave_arvalid), 64'h0);
        @(negedge clock);
        chk("t1_idle_grant", 64'(grant), 64'h0);
        @(negedge clock);
        chk("t1_addr_grant", 64'(grant), 64'h1);
        chk("t1_slave_ar", {31'h0, io_slave_arvalid, io_slave_araddr}, {31'h0, 1'b1, 32'h3000_0000});
        chk("t1_arready", {62'h0, m0_arready, m1_arready}, 64'h2);
        @(posedge clock); #1 m0_arvalid = 1'b0;
        @(negedge clock);
        chk("t1_data_grant", 64'(grant), 64'h1);
        chk("t1_rdata", m0_rdata, 64'h413);
        chk("t1_rlast", {62'h0, m0_rvalid, m0_rlast}, 64'h3);
        @(negedge clock);
        chk("t1_back_idle", 64'(grant), 64'h0);
        chk("t1_sb_empty", 64'(sb.size()), 64'h0);

        // Round-robin with both masters requesting continuously
        do_reset("t2_reset");
        rr_grants.delete();
        m0_araddr = 32'h1000_0000; m0_arid = 4'h2; m0_arlen = 8'd0;
        m1_araddr = 32'h2000_0000; m1_arid = 4'h3; m1_arlen = 8'd0;
        push_beats(0, 32'h1000_0000, 4'h2, 1);
        push_beats(1, 32'h2000_0000, 4'h3, 1);
        push_beats(0, 32'h1000_0000, 4'h2, 1);
        push_beats(1, 32'h2000_0000, 4'h3, 1);
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        hs = 0;
        for (int c = 0; c < 80 && hs < 4; c++) begin
            @(negedge clock);
            if (io_slave_arvalid && io_slave_arready) begin
                hs++;
                if (hs == 4) begin
                    @(posedge clock); #1;
                    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
                end
            end
        end
        chk("t2_ar_count", 64'(hs), 64'h4);
        drain("t2", 40);
        chk("t2_grant_count", 64'(rr_grants.size()), 64'h4);
        for (int i = 0; i < rr_grants.size() && i < 4; i++)
            chk("t2_grant_order", 64'(rr_grants[i]), (i % 2 == 0) ? 64'h1 : 64'h2);

        // Fixed priority: m0 wins every tie while it keeps requesting
        fp_grants.delete();
        fp_m0_arvalid = 1'b1; fp_m1_arvalid = 1'b1;
        repeat (20) @(posedge clock);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (fp_m0_arready) begin
                @(posedge clock); #1;
                fp_m0_arvalid = 1'b0;
                break;
            end
        end
        n_m0 = 0; n_m1 = 0;
        foreach (fp_grants[i]) begin
            if (fp_grants[i] == 2'b01) n_m0++;
            if (fp_grants[i] == 2'b10) n_m1++;
        end
        chk("t3_m1_starved", 64'(n_m1), 64'h0);
        chk("t3_m0_bursts", 64'(n_m0 >= 4), 64'h1);
        got_m1 = 1'b0;
        for (int c = 0; c < 12 && !got_m1; c++) begin
            @(negedge clock);
            if (fp_grant == 2'b10) got_m1 = 1'b1;
        end
        chk("t3_m1_after_m0_drops", 64'(got_m1), 64'h1);
        fp_m1_arvalid = 1'b0;
        repeat (4) @(posedge clock);

        // 4-beat m1 burst with a stuttering rready
        push_beats(1, 32'h4000_0100, 4'h5, 4);
        issue("t4", 1, 32'h4000_0100, 8'd3, 4'h5);
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (sb.size() == 0) break;
            m1_rready = ~m1_rready;
        end
        chk("t4_drained", 64'(sb.size()), 64'h0);
        chk("t4_idle_grant", 64'(grant), 64'h0);
        chk("t4_proto_err", 64'(proto_err), 64'h0);
        m1_rready = 1'b1;

        // rlast tied high on a 4-beat burst: ends after the first beat
        rlast_mode = 2'd1;
        push_beats(0, 32'h5000_0000, 4'h6, 1);
        issue("t5", 0, 32'h5000_0000, 8'd3, 4'h6);
        drain("t5", 20);
        chk("t5_proto_err", 64'(proto_err), 64'h1);
        repeat (3) @(negedge clock);
        chk("t5_stays_idle", 64'(grant), 64'h0);
        rlast_mode = 2'd0;
        do_reset("t5_reset");

        // Slave never asserts rlast: final counted beat is forced last
        rlast_mode = 2'd2;
        push_beats(1, 32'h6000_0000, 4'h7, 2);
        issue("t6", 1, 32'h6000_0000, 8'd1, 4'h7);
        drain("t6", 20);
        chk("t6_proto_err", 64'(proto_err), 64'h1);
        rlast_mode = 2'd0;
        do_reset("t6_reset");

        // Reset lands mid-burst, then a fresh m1 request is served
        m1_rready = 1'b0;
        issue("t7", 1, 32'h7000_0000, 8'd3, 4'h8);
        repeat (2) @(posedge clock);
        #1 chk("t7_in_data", {62'h0, grant}, 64'h2);
        rst_n = 1'b0;
        #1 check_reset("t7_async");
        sb.delete();
        @(negedge clock) rst_n = 1'b1;
        m1_rready = 1'b1;
        rr_grants.delete();
        push_beats(1, 32'h7000_0040, 4'h9, 1);
        issue("t7_after", 1, 32'h7000_0040, 8'd0, 4'h9);
        drain("t7_after", 20);
        chk("t7_regrant", 64'(rr_grants.size() == 1 && rr_grants[0] == 2'b10), 64'h1);
        chk("t7_proto_err", 64'(proto_err), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
